// File: rtl/xs128_stim_gen.sv
// xs128_stim_gen: xorshift128+ stimulus generator.
//   Fills a packed LANES x W beat from successive 64-bit PRNG words (one word
//   per cycle while filling) and hands out req_len beats over valid/ready.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   seed_load/seed_a/_b   load PRNG state (IDLE only; all-zero seed -> state_b=1)
//   req_valid/ready/len   beat-run request, len 0 is a no-op
//   out_valid/ready/data  beat stream, lane 0 in LSBs
//   state_a/state_b       registered PRNG state, for seed-after readback
//   busy                  high while filling or holding a beat
module xs128_stim_gen #(
  parameter int LANES = 4,
  parameter int W     = 16,
  parameter int LEN_W = 8,
  parameter int FOLD  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_load,
  input  logic [63:0]               seed_a,
  input  logic [63:0]               seed_b,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [LEN_W-1:0]          req_len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0][W-1:0]   out_data,
  output logic [63:0]               state_a,
  output logic [63:0]               state_b,
  output logic                      busy
);

  localparam int TOT = LANES * W;
  localparam int S   = (TOT + 63) / 64;          // PRNG steps per beat
  localparam int SW  = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, FILL, HOLD} st_t;

  st_t              st, st_nxt;
  logic [63:0]      sa, sb;
  logic [LEN_W-1:0] rem;
  logic [SW-1:0]    step;
  logic [TOT-1:0]   flat, flat_nxt;
  logic             last_step;

  // xorshift128+ step: s1 = sa, s0 = sb
  logic [63:0] t, nb, word, wout;
  always_comb begin
    t    = sa ^ (sa << 23);
    nb   = t ^ sb ^ (t >> 17) ^ (sb >> 26);
    word = nb + sb;
    wout = (FOLD != 0) ? (word ^ (word >> 32)) : word;
  end

  assign last_step = (step == SW'(S - 1));
  assign req_ready = !rst && (st == IDLE) && !seed_load;
  assign out_valid = (st == HOLD);
  assign busy      = (st != IDLE);
  assign out_data  = flat;
  assign state_a   = sa;
  assign state_b   = sb;

  // Step k owns flattened bits [64k +: 64]; the top segment is truncated.
  for (genvar k = 0; k < S; k++) begin : g_seg
    localparam int LO = 64 * k;
    localparam int N  = ((TOT - LO) < 64) ? (TOT - LO) : 64;
    assign flat_nxt[LO +: N] = (st == FILL && step == SW'(k)) ? wout[N-1:0]
                                                             : flat[LO +: N];
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: if (req_valid && req_ready && req_len != '0) st_nxt = FILL;
      FILL: if (last_step) st_nxt = HOLD;
      HOLD: if (out_ready) st_nxt = (rem == LEN_W'(1)) ? IDLE : FILL;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= 64'h1;
      sb   <= 64'h2;
      rem  <= '0;
      step <= '0;
      flat <= '0;
    end else begin
      flat <= flat_nxt;
      case (st)
        IDLE: begin
          step <= '0;
          if (seed_load) begin
            sa <= seed_a;
            // all-zero state is a fixed point of xorshift
            sb <= (seed_a == 64'h0 && seed_b == 64'h0) ? 64'h1 : seed_b;
          end else if (req_valid && req_len != '0) begin
            rem <= req_len;
          end
        end
        FILL: begin
          sa   <= sb;
          sb   <= nb;
          step <= last_step ? '0 : step + SW'(1);
        end
        HOLD: if (out_ready) rem <= rem - LEN_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/xs128_stim_gen.md
Name: xs128_stim_gen

Overview:
- Parametrised xorshift128+ stimulus generator for the seeded random-design flow; state is two 64-bit words, the same seed pair format the generator records per test ("Seed" / "Seed after").
- Fills a packed multi-lane output bus ([LANES-1:0][W-1:0]) from successive PRNG words.
- Emits a requested number of beats over a valid/ready stream.
- Exposes current state for seed-after readback.

Parameters:
LANES, 4, number of output lanes (1..16)
W, 16, bits per lane (1..64)
LEN_W, 8, width of beat-count request field
FOLD, 0, 0 = take raw PRNG word; 1 = word XOR (word >> 32) before packing

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
seed_load  input  1  load seed_a/seed_b into state (sampled only in IDLE)
seed_a  input  64  state word 0
seed_b  input  64  state word 1
req_valid  input  1  beat-run request valid
req_ready  output  1  high only in IDLE and seed_load low
req_len  input  LEN_W  beats requested; 0 = no-op
out_valid  output  1  out_data holds a complete beat
out_ready  input  1  consumer accepts beat
out_data  output  [LANES-1:0][W-1:0]  packed beat, lane 0 in LSBs
state_a  output  64  current state word 0
state_b  output  64  current state word 1
busy  output  1  high in FILL or HOLD

Behaviour:
- Reset: state_a=64'h1, state_b=64'h2, FSM=IDLE, out_valid=0, out_data=0, req_ready=0 during reset cycle then 1, busy=0, remaining count=0.
- Step (one per cycle in FILL): s1=state_a, s0=state_b; state_a<=s0; t=s1^(s1<<23); state_b<=t^s0^(t>>17)^(s0>>26); word=new state_b+s0 (mod 2^64). FOLD=1 applies fold to word only, never to state.
- S = ceil(LANES*W/64) steps per beat. Step k (0-based) writes flattened bits [64k+63:64k]; last step truncated to remaining bits.
- seed_load in IDLE: state<=seeds next cycle. If seed_a==0 and seed_b==0, state_b<=64'h1 instead (avoid lock-up). seed_load outside IDLE ignored. seed_load and req_valid same cycle: load wins, request not accepted (req_ready=0).
- FSM:
  - IDLE: req_valid&req_ready&req_len!=0 -> FILL, remaining<=req_len. req_len==0 accepted, stays IDLE.
  - FILL: one step/cycle; after S-th step -> HOLD with out_valid=1 next cycle.
  - HOLD: out_data stable, out_valid=1 until out_ready; on handshake remaining-=1; if remaining becomes 0 -> IDLE, else -> FILL.
- Latency: first out_valid exactly S+1 cycles after accepting handshake; back-to-back beats spaced S+1 cycles min.
- out_data held between beats, overwritten word-by-word in FILL; out_valid=0 during FILL.
- req_len = 2^LEN_W-1 max; no wrap of remaining counter.
- rst mid-run: aborts immediately, all values to reset values, partial beat discarded.
- state_a/state_b always reflect registered state (readback valid any cycle).

Test Plan:
- Reset, LANES=4,W=16, req_len=1, out_ready=1 -> after 2 cycles out_valid=1, out_data lanes {3..0}={0x0000,0x0000,0x0080,0x0045}; state_b=64'h800043 (check state_a=64'h2).
- Same config, req_len=2 -> second beat lanes {0x0000,0x0000,0x0200,0x0104}, spaced 2 cycles, then IDLE, req_ready=1.
- LANES=5,W=16, req_len=1 -> out_valid 3 cycles after accept; lanes 0..3 as beat 1 above, lane4=0x0104.
- seed_load with seed_a=0,seed_b=0 -> state_a=0, state_b=64'h1; seed_load asserted in FILL -> state unchanged.
- out_ready held low 10 cycles in HOLD -> out_data/state stable, out_valid=1; then release -> single handshake, remaining decremented by exactly 1.
- rst asserted in FILL mid-beat -> next cycle state=(1,2), out_valid=0, busy=0; req_len=0 request -> accepted, no beat produced.
